lock_sequencer: RTL and testbench

Top-level control FSM for the digital lock. It collects keypad digits into a 16-bit BCD entry and sequences the password comparison. It drives the lock enable for a timed unlock window, counts consecutive failures into a timed lockout, and issues the write that reprograms the stored password. It sits between the keypad decoder and the password register, and is paced by the system's 100 Hz tick strobe.

---
 rtl/lock_sequencer_pkg.sv | 20 ++
 rtl/lock_sequencer_if.sv | 28 ++
 rtl/lock_sequencer_tick_timer.sv | 33 +++
 rtl/lock_sequencer.sv | 162 ++++++++++++++++
 tb/tb_lock_sequencer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/lock_sequencer_pkg.sv
// Shared types and key codes for the digital lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        UNLOCKED,
        FAIL,
        LOCKOUT
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_SET   = 4'hC;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_sequencer_if.sv
// Keypad, password-register and status signals of the lock controller.
// key_valid and pw_wr_en are single-cycle strobes with no backpressure: data is
// qualified only in the cycle its strobe is high, and the receiver must accept it.
interface lock_sequencer_if;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] password;
    logic [15:0] pw_16bit;
    logic [2:0]  digit_cnt;
    logic        enb_lock;
    logic        fail_led;
    logic        alarm;
    logic [1:0]  fail_cnt;
    logic        pw_wr_en;
    logic [15:0] pw_wr_data;

    modport master (
        output key_valid, key_code, password,
        input  pw_16bit, digit_cnt, enb_lock, fail_led, alarm, fail_cnt,
               pw_wr_en, pw_wr_data
    );

    modport slave (
        input  key_valid, key_code, password,
        output pw_16bit, digit_cnt, enb_lock, fail_led, alarm, fail_cnt,
               pw_wr_en, pw_wr_data
    );
endinterface

// File: rtl/lock_sequencer_tick_timer.sv
// Loadable down-counter paced by the tick strobe; expire_o marks the last tick.
module tick_timer #(
    parameter int TMR_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    output logic             expire_o
);
    logic [TMR_W-1:0] cnt_q, cnt_d;

    // A load wins over a coincident tick, so the entry-cycle tick is not counted.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = tick_i && !load_i && (cnt_q == TMR_W'(1));
endmodule

// File: rtl/lock_sequencer.sv
// Lock control FSM: keypad entry buffer, password check, unlock window,
// failure counting with lockout, and password reprogramming strobe.
module lock_sequencer
    import lock_pkg::*;
#(
    parameter int UNLOCK_TICKS  = 500,
    parameter int FAIL_TICKS    = 100,
    parameter int LOCKOUT_TICKS = 3000,
    parameter int MAX_FAIL      = 3,
    parameter int TMR_W         = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    lock_sequencer_if.slave   bus,
    output state_t            state_dbg
);
    localparam logic [1:0] MAX_FAIL_C = 2'(MAX_FAIL);

    state_t      state_q, state_d;
    logic [15:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  fail_q, fail_d, fail_inc;
    logic        wr_en_q, wr_en_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        enb_q, fail_led_q, alarm_q;
    logic        tmr_load, tmr_expire;
    logic [TMR_W-1:0] tmr_val;
    logic [15:0] buf_key;
    logic [2:0]  cnt_key;

    tick_timer #(.TMR_W(TMR_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (tick),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Buffer contents after a key in a digit-collecting state; a 5th digit is dropped.
    always_comb begin
        buf_key = buf_q;
        cnt_key = cnt_q;
        if (is_digit(bus.key_code)) begin
            if (cnt_q < 3'd4) begin
                buf_key = {buf_q[11:0], bus.key_code};
                cnt_key = cnt_q + 3'd1;
            end
        end else if (bus.key_code == KEY_CLEAR) begin
            buf_key = '0;
            cnt_key = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        fail_d    = fail_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        fail_inc  = (fail_q >= MAX_FAIL_C) ? MAX_FAIL_C : fail_q + 2'd1;
        case (state_q)
            IDLE: begin
                if (bus.key_valid) begin
                    buf_d = buf_key;
                    cnt_d = cnt_key;
                    if (bus.key_code == KEY_ENTER) state_d = CHECK;
                end
            end
            CHECK: begin
                // A short entry never matches, so it falls through to the failure path.
                buf_d = '0;
                cnt_d = '0;
                if (cnt_q == 3'd4 && buf_q == bus.password) begin
                    fail_d  = '0;
                    state_d = UNLOCKED;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == MAX_FAIL_C) ? LOCKOUT : FAIL;
                end
            end
            UNLOCKED: begin
                if (tmr_expire) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (bus.key_valid) begin
                    buf_d = buf_key;
                    cnt_d = cnt_key;
                    if (bus.key_code == KEY_SET && cnt_q == 3'd4) begin
                        wr_en_d   = 1'b1;
                        wr_data_d = buf_q;
                        buf_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else if (bus.key_code == KEY_ENTER) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            FAIL: begin
                if (tmr_expire) state_d = IDLE;
            end
            LOCKOUT: begin
                if (tmr_expire) begin
                    fail_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            UNLOCKED: tmr_val = TMR_W'(UNLOCK_TICKS);
            FAIL:     tmr_val = TMR_W'(FAIL_TICKS);
            LOCKOUT:  tmr_val = TMR_W'(LOCKOUT_TICKS);
            default:  tmr_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            fail_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            enb_q      <= 1'b0;
            fail_led_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            fail_q     <= fail_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            enb_q      <= (state_d == UNLOCKED);
            fail_led_q <= (state_d == FAIL);
            alarm_q    <= (state_d == LOCKOUT);
        end
    end

    assign bus.pw_16bit   = buf_q;
    assign bus.digit_cnt  = cnt_q;
    assign bus.enb_lock   = enb_q;
    assign bus.fail_led   = fail_led_q;
    assign bus.alarm      = alarm_q;
    assign bus.fail_cnt   = fail_q;
    assign bus.pw_wr_en   = wr_en_q;
    assign bus.pw_wr_data = wr_data_q;
    assign state_dbg      = state_q;
endmodule

// File: tb/tb_lock_sequencer.sv
// Bench for lock_sequencer: status-change events are checked against a queue of
// hand-computed expectations, plus direct checks of the entry buffer and state.
module tb_lock_sequencer;
    import lock_pkg::*;

    localparam int W = 34;

    logic   clk = 1'b0;
    logic   reset;
    logic   tick;
    state_t state_dbg;

    lock_sequencer_if bus();

    lock_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    wire [3:0] status = {bus.enb_lock, bus.fail_led, bus.alarm, bus.pw_wr_en};

    // Event word: {enb,fail_led,alarm,wr_en, fail_cnt, wr_data, ticks since previous event}
    function automatic logic [W-1:0] mk(input logic [3:0] st, input logic [1:0] fc,
                                        input logic [15:0] d, input int t);
        logic [11:0] t12;
        t12 = t[11:0];
        return {st, fc, d, t12};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        logic [3:0]   prev;
        logic [W-1:0] obs;
        logic [W-1:0] e;
        int           ticks;
        prev  = '0;
        ticks = 0;
        forever begin
            @(posedge clk);
            if (tick === 1'b1) ticks++;
            @(negedge clk);
            if (status !== prev) begin
                obs = mk(status, bus.fail_cnt, bus.pw_wr_data, ticks);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL event: unexpected event %h (status %b)", obs, status);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_err++;
                        $display("FAIL event: got st=%b fc=%0d data=%h ticks=%0d expected st=%b fc=%0d data=%h ticks=%0d",
                                 obs[33:30], obs[29:28], obs[27:12], obs[11:0],
                                 e[33:30], e[29:28], e[27:12], e[11:0]);
                    end
                end
                prev  = status;
                ticks = 0;
            end
        end
    end

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        @(negedge clk);
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
    endtask

    task automatic keys4(input logic [15:0] v);
        for (int i = 0; i < 4; i++) press(v[15-4*i -: 4]);
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk) tick = 1'b1;
            @(negedge clk) tick = 1'b0;
        end
    endtask

    // Waits for the status outputs to change, optionally pulsing tick every other cycle.
    task automatic wait_change(input string name, input int max_cyc, input bit use_tick);
        logic [3:0] s0;
        bit         seen;
        s0   = status;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (status !== s0) seen = 1'b1;
            else tick = use_tick ? ~tick : 1'b0;
        end
        tick = 1'b0;
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no status change within %0d cycles (status %b)", name, max_cyc, s0);
        end
    endtask

    initial begin
        reset         = 1'b1;
        tick          = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        bus.password  = 16'h1234;
        repeat (3) @(negedge clk);
        check("rst_enb", 32'(bus.enb_lock), 0);
        check("rst_fail_led", 32'(bus.fail_led), 0);
        check("rst_alarm", 32'(bus.alarm), 0);
        check("rst_fail_cnt", 32'(bus.fail_cnt), 0);
        check("rst_wr_en", 32'(bus.pw_wr_en), 0);
        check("rst_pw", 32'(bus.pw_16bit), 0);
        check("rst_cnt", 32'(bus.digit_cnt), 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        reset = 1'b0;

        // Correct entry, unlock window of exactly 500 ticks
        keys4(16'h1234);
        check("entry_pw", 32'(bus.pw_16bit), 32'h1234);
        check("entry_cnt", 32'(bus.digit_cnt), 4);
        exp_q.push_back(mk(4'b1000, 2'd0, 16'h0000, 0));
        press(KEY_ENTER);
        check("enter_state_check", 32'(state_dbg), 32'(CHECK));
        check("enter_enb_early", 32'(bus.enb_lock), 0);
        @(negedge clk);
        check("enter_enb_on", 32'(bus.enb_lock), 1);
        check("check_clears_cnt", 32'(bus.digit_cnt), 0);
        exp_q.push_back(mk(4'b0000, 2'd0, 16'h0000, 500));
        wait_change("unlock_window", 1200, 1'b1);
        check("unlock_end_state", 32'(state_dbg), 32'(IDLE));

        // Three wrong entries: two FAIL windows, then LOCKOUT
        for (int a = 1; a <= 3; a++) begin
            keys4(16'h1235);
            if (a < 3) exp_q.push_back(mk(4'b0100, 2'(a), 16'h0000, 0));
            else       exp_q.push_back(mk(4'b0010, 2'd3, 16'h0000, 0));
            press(KEY_ENTER);
            wait_change("wrong_rise", 4, 1'b0);
            if (a < 3) begin
                exp_q.push_back(mk(4'b0000, 2'(a), 16'h0000, 100));
                wait_change("fail_window", 300, 1'b1);
            end else begin
                exp_q.push_back(mk(4'b0000, 2'd0, 16'h0000, 3000));
                wait_change("lockout_window", 6500, 1'b1);
            end
        end
        check("after_lockout_fail_cnt", 32'(bus.fail_cnt), 0);

        // Short entry counts as a failure
        press(4'h1);
        press(4'h2);
        exp_q.push_back(mk(4'b0100, 2'd1, 16'h0000, 0));
        press(KEY_ENTER);
        wait_change("short_rise", 4, 1'b0);
        check("short_fail_cnt", 32'(bus.fail_cnt), 1);
        check("short_fail_led", 32'(bus.fail_led), 1);
        exp_q.push_back(mk(4'b0000, 2'd1, 16'h0000, 100));
        wait_change("short_window", 300, 1'b1);

        // Fifth digit dropped, undefined key ignored, clear
        keys4(16'h1234);
        press(4'h5);
        check("fifth_pw", 32'(bus.pw_16bit), 32'h1234);
        check("fifth_cnt", 32'(bus.digit_cnt), 4);
        press(KEY_CLEAR);
        press(4'h1);
        press(4'hE);
        check("ignored_key_pw", 32'(bus.pw_16bit), 32'h0001);
        check("ignored_key_cnt", 32'(bus.digit_cnt), 1);
        press(KEY_CLEAR);
        check("clear_cnt", 32'(bus.digit_cnt), 0);

        // Unlock, then reprogram the password
        keys4(16'h1234);
        exp_q.push_back(mk(4'b1000, 2'd0, 16'h0000, 0));
        press(KEY_ENTER);
        wait_change("unlock2_rise", 4, 1'b0);
        press(4'h9);
        press(4'h8);
        press(KEY_SET);
        check("short_set_state", 32'(state_dbg), 32'(UNLOCKED));
        check("short_set_cnt", 32'(bus.digit_cnt), 2);
        press(4'h7);
        press(4'h6);
        exp_q.push_back(mk(4'b0001, 2'd0, 16'h9876, 0));
        exp_q.push_back(mk(4'b0000, 2'd0, 16'h9876, 0));
        press(KEY_SET);
        check("set_wr_data", 32'(bus.pw_wr_data), 32'h9876);
        check("set_state", 32'(state_dbg), 32'(IDLE));
        check("set_cnt", 32'(bus.digit_cnt), 0);
        @(negedge clk);
        check("set_wr_en_one_cycle", 32'(bus.pw_wr_en), 0);

        // Key coincident with the final unlock tick is discarded
        keys4(16'h1234);
        exp_q.push_back(mk(4'b1000, 2'd0, 16'h9876, 0));
        press(KEY_ENTER);
        wait_change("unlock3_rise", 4, 1'b0);
        press(4'h4);
        press(4'h4);
        check("pre_expiry_cnt", 32'(bus.digit_cnt), 2);
        exp_q.push_back(mk(4'b0000, 2'd0, 16'h9876, 500));
        tick_n(499);
        @(negedge clk);
        tick          = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h5;
        @(negedge clk);
        tick          = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        check("expiry_key_state", 32'(state_dbg), 32'(IDLE));
        check("expiry_key_cnt", 32'(bus.digit_cnt), 0);
        check("expiry_key_pw", 32'(bus.pw_16bit), 0);

        // Drive into LOCKOUT with empty entries, then reset mid-count
        for (int a = 1; a <= 2; a++) begin
            exp_q.push_back(mk(4'b0100, 2'(a), 16'h9876, 0));
            press(KEY_ENTER);
            wait_change("empty_rise", 4, 1'b0);
            exp_q.push_back(mk(4'b0000, 2'(a), 16'h9876, 100));
            wait_change("empty_window", 300, 1'b1);
        end
        exp_q.push_back(mk(4'b0010, 2'd3, 16'h9876, 0));
        press(KEY_ENTER);
        wait_change("lockout2_rise", 4, 1'b0);
        tick_n(50);
        exp_q.push_back(mk(4'b0000, 2'd0, 16'h0000, 50));
        #2 reset = 1'b1;
        #1;
        check("async_rst_alarm", 32'(bus.alarm), 0);
        check("async_rst_fail_cnt", 32'(bus.fail_cnt), 0);
        check("async_rst_wr_data", 32'(bus.pw_wr_data), 0);
        check("async_rst_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        keys4(16'h1234);
        exp_q.push_back(mk(4'b1000, 2'd0, 16'h0000, 0));
        press(KEY_ENTER);
        wait_change("post_reset_unlock", 4, 1'b0);
        check("post_reset_enb", 32'(bus.enb_lock), 1);

        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
